// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer with sub-word extract, RMW stores and access checks; ports clk/reset, req_* request, resp_* response, mem_* memory port; optional MAU_STATS_EN adds stat_loads/stat_stores/stat_errors
module mem_access_unit #(
  parameter int MEM_DEPTH = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_dout
`ifdef MAU_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_errors
`endif
);
  typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP, ERR} state_t;
  localparam logic [32:0] LIMIT = 33'(MEM_DEPTH) * 33'd4;
  state_t      r_state, w_next;
  logic        r_write, r_unsigned;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_merge, r_rdata;
  logic        w_err;
  logic [4:0]  w_sh;
  logic [31:0] w_lane, w_keep, w_mask, w_ext, w_merged;
  assign w_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                 (req_size == 2'b10 && req_addr[1:0] != 2'b00) || {1'b0, req_addr} >= LIMIT;
  assign w_sh     = r_size[0] ? {r_addr[1], 4'b0} : {r_addr[1:0], 3'b0};
  assign w_lane   = mem_dout >> w_sh;
  assign w_keep   = r_size[0] ? 32'hFFFF : 32'hFF;
  assign w_mask   = w_keep << w_sh;
  assign w_merged = (mem_dout & ~w_mask) | ((r_wdata & w_keep) << w_sh);
  assign w_ext    = r_size == 2'b00 ? (r_unsigned ? {24'b0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]}) :
                    r_size == 2'b01 ? (r_unsigned ? {16'b0, w_lane[15:0]} : {{16{w_lane[15]}}, w_lane[15:0]}) :
                    mem_dout;
  always_comb begin
    w_next     = IDLE;
    req_ready  = r_state == IDLE;
    mem_read   = !reset && (r_state == READ || r_state == RMW_RD);
    mem_write  = !reset && r_state == WRITE;
    resp_valid = r_state == RESP || r_state == ERR;
    resp_err   = r_state == ERR;
    resp_rdata = (r_state == RESP && !r_write) ? r_rdata : '0;
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_din    = r_merge;
    case (r_state)
      IDLE:    w_next = !req_valid ? IDLE : w_err ? ERR : !req_write ? READ : req_size == 2'b10 ? WRITE : RMW_RD;
      READ:    w_next = RESP;
      RMW_RD:  w_next = WRITE;
      WRITE:   w_next = RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_merge    <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_valid) begin
        r_write    <= req_write;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_merge    <= req_wdata;
      end
      if (r_state == READ) r_rdata <= w_ext;
      if (r_state == RMW_RD) r_merge <= w_merged;
    end
  end
`ifdef MAU_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errors <= '0;
    end else begin
      if (r_state == RESP && !r_write) stat_loads <= stat_loads + 32'd1;
      if (r_state == RESP && r_write) stat_stores <= stat_stores + 32'd1;
      if (r_state == ERR) stat_errors <= stat_errors + 32'd1;
    end
  end
`endif
endmodule
